cache_mem_controller: RTL and testbench

//  Miss-service sequencer sitting directly downstream of the fully-associative cache and upstream of
//  the 128x5 backing RAM. On a cache miss it accepts one request, writes back the dirty victim when

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_mem_controller_sat_counter.sv | 35 +++
 rtl/cache_mem_controller.sv | 146 ++++++++++++++
 tb/tb_cache_mem_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Definitions shared by the cache miss-service controller and the blocks around it.
//   CACHE_ADDR_W : RAM word address width (same as the cache tag width)
//   CACHE_DATA_W : block/word width
//   LAT_W        : width of the read-latency down-counter (covers MEM_RD_LAT-1 for 1..4)
//   state_t      : miss-service sequencer states
//   lat_load     : reload value for the latency counter for a given RAM read latency
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int CACHE_ADDR_W = 7;
    localparam int CACHE_DATA_W = 5;
    localparam int LAT_W        = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    // WAIT runs for exactly 'lat' cycles: the counter starts at lat-1 and
    // the capture happens in the cycle where it reads zero.
    function automatic logic [LAT_W-1:0] lat_load(input int lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/cache_mem_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Free-running event counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   i_clock : clock, counts on the rising edge
//   i_reset : synchronous active-high clear
//   i_inc   : count one event this cycle
//   o_count : current count (saturating)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_mem_controller.sv
// -----------------------------------------------------------------------------
// cache_mem_controller
// Miss-service sequencer between the fully-associative cache and the backing
// RAM. One miss is accepted at a time; a dirty victim is written back first,
// then the fill block is read (MEM_RD_LAT cycles) and returned to the cache with
// a single-cycle fill_valid pulse.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   req_valid/req_ready : miss request handshake (ready only while idle)
//   req_wb              : victim is dirty, write it back before the fill
//   req_wb_addr/_data   : victim RAM address and block data
//   req_addr            : address of the missing block
//   fill_valid          : one-cycle pulse, fill_data holds the new block
//   fill_data           : last block read from RAM (held between fills)
//   mem_addr/wdata/we   : RAM address, write data, write enable
//   mem_rdata           : RAM read data, valid MEM_RD_LAT cycles after address
//   busy                : sequencer is not idle
//   wb_count/fill_count : saturating counts of completed writebacks / fills
// -----------------------------------------------------------------------------
module cache_mem_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W     = CACHE_ADDR_W,
    parameter int DATA_W     = CACHE_DATA_W,
    parameter int MEM_RD_LAT = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [DATA_W-1:0] req_wb_data,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  wb_count,
    output logic [CNT_W-1:0]  fill_count
);

    localparam logic [LAT_W-1:0] LAT_LOAD = lat_load(MEM_RD_LAT);

    state_t             r_state;
    logic               r_req_wb;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [DATA_W-1:0]  r_wb_data;
    logic [ADDR_W-1:0]  r_fill_addr;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [DATA_W-1:0]  r_fill_data;

    logic               w_accept;
    logic               w_wb_inc;
    logic               w_fill_inc;

    // Ready is a pure function of the registered state, so the handshake
    // never depends combinationally on req_valid.
    assign w_accept = req_valid && (r_state == IDLE);

    // Sequencer: request latches, latency counter and fill capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_wb    <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_fill_addr <= '0;
            r_lat_cnt   <= '0;
            r_fill_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_wb    <= req_wb;
                        r_wb_addr   <= req_wb_addr;
                        r_wb_data   <= req_wb_data;
                        r_fill_addr <= req_addr;
                        r_state     <= req_wb ? WB : RD;
                    end
                end
                WB: begin
                    r_state <= RD;
                end
                RD: begin
                    r_lat_cnt <= LAT_LOAD;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    // mem_rdata for the RD address is valid in the cycle the counter hits zero
                    if (r_lat_cnt == '0) begin
                        r_fill_data <= mem_rdata;
                        r_state     <= DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state and latches only. The fill address
    // stays on mem_addr from RD onward, so the RAM sees a stable address for the
    // whole read latency.
    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign mem_we     = (r_state == WB);
    assign mem_addr   = (r_state == WB) ? r_wb_addr : r_fill_addr;
    assign mem_wdata  = r_wb_data;
    assign fill_valid = (r_state == DONE);
    assign fill_data  = r_fill_data;

    // WB is only entered for a dirty victim; the latch keeps the count tied to
    // the request that actually asked for a writeback.
    assign w_wb_inc   = (r_state == WB) && r_req_wb;
    assign w_fill_inc = (r_state == DONE);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_wb_cnt (
        .i_clock (clock),
        .i_reset (reset),
        .i_inc   (w_wb_inc),
        .o_count (wb_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_fill_cnt (
        .i_clock (clock),
        .i_reset (reset),
        .i_inc   (w_fill_inc),
        .o_count (fill_count)
    );

endmodule

// File: tb/tb_cache_mem_controller.sv
module tb_cache_mem_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // shared stimulus, per-instance request valid
    logic       reset;
    logic       req_wb;
    logic [6:0] req_wb_addr;
    logic [4:0] req_wb_data;
    logic [6:0] req_addr;
    logic       req_valid1, req_valid3;
    logic       init_ram;
    bit         sel;

    // instance with MEM_RD_LAT=1
    logic       req_ready1, fill_valid1, mem_we1, busy1;
    logic [4:0] fill_data1, mem_wdata1, mem_rdata1;
    logic [6:0] mem_addr1;
    logic [7:0] wb_count1, fill_count1;

    // instance with MEM_RD_LAT=3
    logic       req_ready3, fill_valid3, mem_we3, busy3;
    logic [4:0] fill_data3, mem_wdata3, mem_rdata3;
    logic [6:0] mem_addr3;
    logic [7:0] wb_count3, fill_count3;

    cache_mem_controller #(.ADDR_W(7), .DATA_W(5), .MEM_RD_LAT(1), .CNT_W(8)) dut1 (
        .clock(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_addr(req_addr),
        .fill_valid(fill_valid1), .fill_data(fill_data1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_we(mem_we1), .mem_rdata(mem_rdata1), .busy(busy1), .wb_count(wb_count1), .fill_count(fill_count1)
    );

    cache_mem_controller #(.ADDR_W(7), .DATA_W(5), .MEM_RD_LAT(3), .CNT_W(8)) dut3 (
        .clock(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_addr(req_addr),
        .fill_valid(fill_valid3), .fill_data(fill_data3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_we(mem_we3), .mem_rdata(mem_rdata3), .busy(busy3), .wb_count(wb_count3), .fill_count(fill_count3)
    );

    function automatic logic [4:0] ram_init(input int i);
        case (i)
            100:     return 5'd5;
            105:     return 5'd17;
            127:     return 5'd22;
            default: return 5'((i * 13 + 7) % 32);
        endcase
    endfunction

    // backing RAMs: synchronous write, read data delayed by the instance latency
    logic [4:0] ram1 [128];
    logic [4:0] rd1;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 128; i++) ram1[i] <= ram_init(i);
        end else if (mem_we1) begin
            ram1[mem_addr1] <= mem_wdata1;
        end
        rd1 <= ram1[mem_addr1];
    end
    assign mem_rdata1 = rd1;

    logic [4:0] ram3 [128];
    logic [4:0] rp3 [3];
    always @(posedge clk) begin
        if (init_ram) begin
            for (int k = 0; k < 128; k++) ram3[k] <= ram_init(k);
        end else if (mem_we3) begin
            ram3[mem_addr3] <= mem_wdata3;
        end
        rp3[0] <= ram3[mem_addr3];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mem_rdata3 = rp3[2];

    // view of the selected instance
    logic       v_req_ready, v_fill_valid, v_mem_we, v_busy;
    logic [4:0] v_fill_data, v_mem_wdata;
    logic [6:0] v_mem_addr;
    logic [7:0] v_wb_count, v_fill_count;
    always_comb begin
        v_req_ready  = req_ready1;  v_fill_valid = fill_valid1; v_mem_we   = mem_we1;
        v_busy       = busy1;       v_fill_data  = fill_data1;  v_mem_wdata = mem_wdata1;
        v_mem_addr   = mem_addr1;   v_wb_count   = wb_count1;   v_fill_count = fill_count1;
        if (sel) begin
            v_req_ready  = req_ready3;  v_fill_valid = fill_valid3; v_mem_we   = mem_we3;
            v_busy       = busy3;       v_fill_data  = fill_data3;  v_mem_wdata = mem_wdata3;
            v_mem_addr   = mem_addr3;   v_wb_count   = wb_count3;   v_fill_count = fill_count3;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic v);
        if (sel) req_valid3 = v;
        else     req_valid1 = v;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk({nm, "_ready"},  int'(v_req_ready), 1);
        chk({nm, "_fv"},     int'(v_fill_valid), 0);
        chk({nm, "_fd"},     int'(v_fill_data), 0);
        chk({nm, "_we"},     int'(v_mem_we), 0);
        chk({nm, "_addr"},   int'(v_mem_addr), 0);
        chk({nm, "_wdata"},  int'(v_mem_wdata), 0);
        chk({nm, "_busy"},   int'(v_busy), 0);
        chk({nm, "_wbc"},    int'(v_wb_count), 0);
        chk({nm, "_fc"},     int'(v_fill_count), 0);
    endtask

    // One miss from idle; cycle 1 is the first cycle after the accept edge.
    task automatic xact(input bit wb, input logic [6:0] wba, input logic [4:0] wbd,
                        input logic [6:0] a, input logic [4:0] expd, input int lat, input string nm);
        int         exp_c, fc, pulses, we_cnt, ready_busy, rd_c;
        logic [4:0] fd, wd1;
        logic [6:0] wa1, ra;
        logic       rwe;
        exp_c = 2 + lat + (wb ? 1 : 0);
        rd_c  = wb ? 2 : 1;
        chk({nm, "_idle_ready"}, int'(v_req_ready), 1);
        req_wb = wb; req_wb_addr = wba; req_wb_data = wbd; req_addr = a;
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        fc = -1; pulses = 0; we_cnt = 0; ready_busy = 0;
        fd = '0; wd1 = '0; wa1 = '0; ra = '0; rwe = 1'b1;
        for (int c = 1; c <= exp_c + 3; c++) begin
            if (v_fill_valid) begin
                pulses++;
                if (fc < 0) begin fc = c; fd = v_fill_data; end
            end
            if (v_mem_we) we_cnt++;
            if (c == 1) begin wa1 = v_mem_addr; wd1 = v_mem_wdata; end
            if (c == rd_c) begin ra = v_mem_addr; rwe = v_mem_we; end
            if (c <= exp_c && v_req_ready) ready_busy++;
            tick();
        end
        chk({nm, "_latency"}, fc, exp_c);
        chk({nm, "_pulses"},  pulses, 1);
        chk({nm, "_data"},    int'(fd), int'(expd));
        chk({nm, "_held"},    int'(v_fill_data), int'(expd));
        chk({nm, "_we_cycles"}, we_cnt, wb ? 1 : 0);
        chk({nm, "_ready_busy"}, ready_busy, 0);
        chk({nm, "_rd_addr"}, int'(ra), int'(a));
        chk({nm, "_rd_we"},   int'(rwe), 0);
        if (wb) begin
            chk({nm, "_wb_addr"}, int'(wa1), int'(wba));
            chk({nm, "_wb_data"}, int'(wd1), int'(wbd));
        end
    endtask

    typedef struct {
        bit         rst;
        bit         wb;
        logic [6:0] wba;
        logic [4:0] wbd;
        logic [6:0] a;
        logic [4:0] expd;
        int         wbc;
        int         fc;
    } vec_t;

    vec_t       vec [6];
    logic [4:0] model_mem [128];

    initial begin
        int acc, fills, inconsist, nwb;
        bit         rb;
        logic [6:0] ra_w, ra_a;
        logic [4:0] rd_w;

        vec[0] = '{1'b1, 1'b0, 7'd0,   5'd0,  7'd100, 5'd5,  0, 1};
        vec[1] = '{1'b0, 1'b1, 7'd101, 5'd3,  7'd105, 5'd17, 1, 2};
        vec[2] = '{1'b1, 1'b1, 7'd102, 5'd9,  7'd102, 5'd9,  1, 1};
        vec[3] = '{1'b0, 1'b0, 7'd0,   5'd0,  7'd101, 5'd3,  1, 2};
        vec[4] = '{1'b0, 1'b1, 7'd0,   5'd31, 7'd127, 5'd22, 2, 3};
        vec[5] = '{1'b0, 1'b0, 7'd0,   5'd0,  7'd0,   5'd31, 2, 4};

        sel = 1'b0; reset = 1'b1; init_ram = 1'b1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        req_wb = 1'b0; req_wb_addr = '0; req_wb_data = '0; req_addr = '0;
        tick(); tick();
        init_ram = 1'b0;

        // table vectors on the latency-1 instance
        for (int i = 0; i < 6; i++) begin
            if (vec[i].rst) do_reset($sformatf("v%0d_rst", i));
            xact(vec[i].wb, vec[i].wba, vec[i].wbd, vec[i].a, vec[i].expd, 1, $sformatf("v%0d", i));
            chk($sformatf("v%0d_wbc", i), int'(v_wb_count), vec[i].wbc);
            chk($sformatf("v%0d_fc", i),  int'(v_fill_count), vec[i].fc);
        end
        chk("ram101_written", int'(ram1[101]), 3);
        chk("ram0_written",   int'(ram1[0]), 31);

        // req_valid held high across two full writeback+fill sequences
        do_reset("hold_rst");
        req_wb = 1'b1; req_wb_addr = 7'd50; req_wb_data = 5'd12; req_addr = 7'd50;
        req_valid1 = 1'b1;
        acc = 0; fills = 0; inconsist = 0;
        for (int i = 0; i < 10; i++) begin
            if (v_req_ready) acc++;
            if (v_req_ready == v_busy) inconsist++;
            tick();
            if (v_fill_valid) begin
                fills++;
                chk("hold_fill_data", int'(v_fill_data), 12);
            end
        end
        req_valid1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (v_req_ready == v_busy) inconsist++;
            tick();
            if (v_fill_valid) fills++;
        end
        chk("hold_accepts", acc, 2);
        chk("hold_fills", fills, 2);
        chk("hold_ready_vs_busy", inconsist, 0);
        chk("hold_wbc", int'(v_wb_count), 2);
        chk("hold_fc", int'(v_fill_count), 2);

        // reset asserted during the writeback cycle
        do_reset("abort_rst");
        req_wb = 1'b1; req_wb_addr = 7'd60; req_wb_data = 5'd7; req_addr = 7'd61;
        req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("abort_in_wb_we", int'(v_mem_we), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_we", int'(v_mem_we), 0);
        chk("abort_busy", int'(v_busy), 0);
        chk("abort_ready", int'(v_req_ready), 1);
        chk("abort_wbc", int'(v_wb_count), 0);
        chk("abort_fc", int'(v_fill_count), 0);
        fills = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (v_fill_valid) fills++;
        end
        chk("abort_no_fill", fills, 0);

        // randomized traffic on the latency-3 instance against a memory model
        sel = 1'b1;
        do_reset("rand_rst");
        for (int i = 0; i < 128; i++) model_mem[i] = ram_init(i);
        nwb = 0;
        for (int n = 0; n < 300; n++) begin
            rb   = 1'($urandom_range(0, 1));
            ra_w = 7'($urandom_range(0, 127));
            rd_w = 5'($urandom_range(0, 31));
            ra_a = ($urandom_range(0, 3) == 0) ? ra_w : 7'($urandom_range(0, 127));
            if (rb) begin
                model_mem[ra_w] = rd_w;
                nwb++;
            end
            xact(rb, ra_w, rd_w, ra_a, model_mem[ra_a], 3, $sformatf("r%0d", n));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        chk("rand_fc_sat", int'(v_fill_count), 255);
        chk("rand_wbc", int'(v_wb_count), (nwb > 255) ? 255 : nwb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
